shift_serializer: RTL and testbench

//   Parallel-in, serial-out counterpart to the team's DFF-chain serial shift

---
 rtl/shift_serializer_if.sv | 29 ++
 rtl/shift_serializer.sv | 130 +++++++++++++
 tb/tb_shift_serializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_serializer_if.sv
// Word handshake into the serializer and the framed serial stream out of it.
interface shift_serializer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             q;
   logic             q_valid;
   logic             q_last;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  q,
      input  q_valid,
      input  q_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output q,
      output q_valid,
      output q_last
   );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out shifter: one WIDTH-bit word per frame, one bit per clock on q.
// Optional even-parity trailer bit enabled by defining SHIFT_SERIALIZER_PARITY_EN.
module shift_serializer #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MSB_FIRST = 0
) (
   input logic               clk,
   input logic               rstn,
   shift_serializer_if.slave bus
);

`ifdef SHIFT_SERIALIZER_PARITY_EN
   localparam int unsigned NBITS = WIDTH + 1;
`else
   localparam int unsigned NBITS = WIDTH;
`endif
   localparam int unsigned CW    = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             q_valid_q, q_valid_d;
   logic             q_last_q, q_last_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   logic [WIDTH-1:0] ordered_c;
   logic             last_c;
   logic             in_ready_c;
   logic             accept_c;

   // Word rearranged so that bit 0 is always the first to leave.
   always_comb begin
      ordered_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (MSB_FIRST != 0) ordered_c[i] = bus.in_data[int'(WIDTH) - 1 - i];
         else                ordered_c[i] = bus.in_data[i];
      end
   end

   // Ready depends on state/counter only; a new word may land on the last-bit cycle.
   always_comb begin
      last_c     = (state_q == SHIFT) && (cnt_q == LAST_IDX);
      in_ready_c = !rstn && ((state_q == IDLE) || last_c);
      accept_c   = bus.in_valid && in_ready_c;
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      q_d       = 1'b0;
      q_valid_d = 1'b0;
      q_last_d  = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      par_d     = par_q;
`endif

      unique case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            if (last_c) begin
               state_d = IDLE;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               shreg_d   = shreg_q >> 1;
               q_d       = shreg_q[0];
               q_valid_d = 1'b1;
               q_last_d  = (cnt_q == (LAST_IDX - CW'(1)));
`ifdef SHIFT_SERIALIZER_PARITY_EN
               if (cnt_q == CW'(WIDTH - 1)) q_d = par_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A load overrides both the idle hold and the end-of-frame return to IDLE.
      if (accept_c) begin
         state_d   = SHIFT;
         cnt_d     = '0;
         shreg_d   = ordered_c >> 1;
         q_d       = ordered_c[0];
         q_valid_d = 1'b1;
         q_last_d  = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
         par_d     = ^bus.in_data;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         q_q       <= 1'b0;
         q_valid_q <= 1'b0;
         q_last_q  <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         q_last_q  <= q_last_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.q        = q_q;
   assign bus.q_valid  = q_valid_q;
   assign bus.q_last   = q_last_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: directed vector table plus random traffic against a frame-queue model.
module tb_shift_serializer;

   localparam int unsigned W = 4;
`ifdef SHIFT_SERIALIZER_PARITY_EN
   localparam int unsigned NB = W + 1;
`else
   localparam int unsigned NB = W;
`endif

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   shift_serializer_if #(.WIDTH(W)) bus_l ();
   shift_serializer_if #(.WIDTH(W)) bus_m ();

   shift_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_l)
   );

   shift_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_m)
   );

   // Model: each accepted word becomes a queue of pending output bits; one leaves per clock.
   typedef struct packed {
      logic d;
      logic l;
   } obit_t;

   obit_t pend_l[$];
   obit_t pend_m[$];
   obit_t disp_l, disp_m;
   logic  disp_v;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         rst;
      logic         v;
      logic [W-1:0] d;
      logic         e_rdy;
      logic         e_v;
      logic         e_q;
      logic         e_l;
   } vec_t;

   vec_t tbl[$];

   function automatic void push_frame(input logic [W-1:0] w);
      obit_t bl, bm;
      for (int i = 0; i < int'(NB); i++) begin
         if (i < int'(W)) begin
            bl.d = w[i];
            bm.d = w[int'(W) - 1 - i];
         end else begin
            bl.d = ^w;
            bm.d = ^w;
         end
         bl.l = (i == int'(NB) - 1);
         bm.l = bl.l;
         pend_l.push_back(bl);
         pend_m.push_back(bm);
      end
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check ready, advance model, check outputs after the edge.
   task automatic step(input logic r, input logic v, input logic [W-1:0] d, output logic rdy_s);
      logic exp_ready;
      rstn           = r;
      bus_l.in_valid = v;
      bus_l.in_data  = d;
      bus_m.in_valid = v;
      bus_m.in_data  = d;
      exp_ready = !r && (pend_l.size() == 0);
      #1;
      rdy_s = bus_l.in_ready;
      check("in_ready_lsb", bus_l.in_ready, exp_ready);
      check("in_ready_msb", bus_m.in_ready, exp_ready);
      if (r) begin
         pend_l.delete();
         pend_m.delete();
      end else if (v && exp_ready) begin
         push_frame(d);
      end
      if (pend_l.size() > 0) begin
         disp_v = 1'b1;
         disp_l = pend_l.pop_front();
         disp_m = pend_m.pop_front();
      end else begin
         disp_v = 1'b0;
         disp_l = '0;
         disp_m = '0;
      end
      @(posedge clk);
      @(negedge clk);
      check("q_valid_lsb", bus_l.q_valid, disp_v);
      check("q_lsb",       bus_l.q,       disp_l.d);
      check("q_last_lsb",  bus_l.q_last,  disp_l.l);
      check("q_valid_msb", bus_m.q_valid, disp_v);
      check("q_msb",       bus_m.q,       disp_m.d);
      check("q_last_msb",  bus_m.q_last,  disp_m.l);
   endtask

   function automatic void add(input logic r, input logic v, input logic [W-1:0] d,
                               input logic er, input logic ev, input logic eq, input logic el);
      vec_t t;
      t.rst = r; t.v = v; t.d = d;
      t.e_rdy = er; t.e_v = ev; t.e_q = eq; t.e_l = el;
      tbl.push_back(t);
   endfunction

   initial begin
      logic       rdy;
      logic [3:0] exp5;

      rstn           = 1'b1;
      bus_l.in_valid = 1'b0;
      bus_l.in_data  = '0;
      bus_m.in_valid = 1'b0;
      bus_m.in_data  = '0;

`ifdef SHIFT_SERIALIZER_PARITY_EN
      // 1011: data bits 1,1,0,1 then parity 1; last on the parity bit
      add(0, 1, 4'b1011, 1, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 1);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
`else
      // single word 1011
      add(0, 1, 4'b1011, 1, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 1);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
      // back-to-back 0110 then 1001
      add(0, 1, 4'b0110, 1, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 1);
      add(0, 1, 4'b1001, 1, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 1);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
      // 1111 offered mid-frame of 0000 is ignored
      add(0, 1, 4'b0000, 1, 1, 0, 0);
      add(0, 1, 4'b1111, 0, 1, 0, 0);
      add(0, 1, 4'b1111, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 1);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
      // reset mid-frame of 1010, then a fresh 1010
      add(0, 1, 4'b1010, 1, 1, 0, 0);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
      add(0, 1, 4'b1010, 1, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 0, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 1);
      add(0, 0, 4'b0000, 1, 0, 0, 0);
`endif

      @(negedge clk);
      step(1, 0, '0, rdy);
      step(1, 1, 4'b1111, rdy);
      check("rst_q_valid", bus_l.q_valid, 1'b0);
      check("rst_q",       bus_l.q,       1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].v, tbl[i].d, rdy);
         check($sformatf("tbl%0d_ready", i), rdy,           tbl[i].e_rdy);
         check($sformatf("tbl%0d_valid", i), bus_l.q_valid, tbl[i].e_v);
         check($sformatf("tbl%0d_q", i),     bus_l.q,       tbl[i].e_q);
         check($sformatf("tbl%0d_last", i),  bus_l.q_last,  tbl[i].e_l);
      end

      // MSB-first instance sends 1100 as 1,1,0,0
      exp5 = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         step(0, (i == 0), 4'b1100, rdy);
         check($sformatf("msb_first_bit%0d", i), bus_m.q, exp5[i]);
      end
      for (int i = 0; i < int'(NB) - 3; i++) step(0, 0, '0, rdy);
      check("msb_first_idle", bus_m.q_valid, 1'b0);

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
              W'($urandom), rdy);
      end
      step(0, 0, '0, rdy);
      for (int i = 0; i < int'(NB); i++) step(0, 0, '0, rdy);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
